// File: rtl/player_ball_motion.sv
// player_ball_motion
// ------------------
// Motion controller for one player ball. Once per video frame it moves the
// ball sideways from the keyboard, runs a jump/gravity state machine, and
// clamps the ball to the screen edges, the ceiling and the floor.
//
// Ports:
//   Clk        in   1   system clock
//   Reset      in   1   asynchronous, active-low reset
//   frame_clk  in   1   vertical-sync-rate strobe, asynchronous to Clk
//   keycode    in   8   key currently held (8'h00 = none)
//   BallX      out 10   ball centre X
//   BallY      out 10   ball centre Y
//   Ball_size  out 10   ball radius (constant SIZE)
//   airborne   out  1   high while the ball is rising or falling
module player_ball_motion #(
    parameter int          X_START  = 320,
    parameter int          GROUND_Y = 400,
    parameter int          X_MIN    = 0,
    parameter int          X_MAX    = 639,
    parameter int          SIZE     = 4,
    parameter int          X_STEP   = 2,
    parameter int          JUMP_VEL = 12,
    parameter int          GRAVITY  = 1,
    parameter int          MAX_FALL = 12,
    parameter logic [7:0]  KEY_LEFT  = 8'h04,
    parameter logic [7:0]  KEY_RIGHT = 8'h07,
    parameter logic [7:0]  KEY_JUMP  = 8'h1A
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] BallX,
    output logic [9:0] BallY,
    output logic [9:0] Ball_size,
    output logic       airborne
);

    typedef enum logic [1:0] {
        GROUND  = 2'd0,
        RISING  = 2'd1,
        FALLING = 2'd2
    } state_t;

    // Resting centre height and the horizontal clamp points.
    localparam logic [9:0]        REST_Y   = 10'(GROUND_Y - SIZE);
    localparam logic [9:0]        X_LO     = 10'(X_MIN + SIZE);
    localparam logic [9:0]        X_HI     = 10'(X_MAX - SIZE);
    localparam logic [9:0]        X_LO_THR = 10'(X_MIN + SIZE + X_STEP);
    localparam logic [9:0]        X_HI_THR = 10'(X_MAX - SIZE - X_STEP);
    localparam logic [9:0]        X_STEP_V = 10'(X_STEP);

    // Signed 11-bit versions for the vertical arithmetic.
    localparam logic signed [10:0] REST_S     = 11'(GROUND_Y - SIZE);
    localparam logic signed [10:0] SIZE_S     = 11'(SIZE);
    localparam logic signed [10:0] GRAV_S     = 11'(GRAVITY);
    localparam logic signed [10:0] MAXF_S     = 11'(MAX_FALL);
    localparam logic signed [10:0] NEG_JUMP_S = 11'(0 - JUMP_VEL);

    // frame_clk synchronizer and edge detector
    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic tick;

    // motion state
    logic [9:0]         ball_x_reg,  ball_x_next;
    logic [9:0]         ball_y_reg,  ball_y_next;
    logic signed [10:0] vel_y_reg,   vel_y_next;
    state_t             state_reg,   state_next;
    logic               jump_armed_reg;
    logic               airborne_reg;

    // vertical intermediates
    logic signed [10:0] y_ext;
    logic signed [10:0] ny;
    logic signed [10:0] vel_inc;

    assign tick = sync2_reg & ~prev_reg;

    assign y_ext   = signed'({1'b0, ball_y_reg});
    assign ny      = y_ext + vel_y_reg;
    assign vel_inc = vel_y_reg + GRAV_S;

    // Horizontal step with edge clamping; independent of vertical state.
    always_comb begin
        ball_x_next = ball_x_reg;
        if (keycode == KEY_LEFT) begin
            if (ball_x_reg < X_LO_THR)
                ball_x_next = X_LO;
            else
                ball_x_next = ball_x_reg - X_STEP_V;
        end else if (keycode == KEY_RIGHT) begin
            if (ball_x_reg > X_HI_THR)
                ball_x_next = X_HI;
            else
                ball_x_next = ball_x_reg + X_STEP_V;
        end
    end

    // Jump / gravity state machine, evaluated for one frame step.
    always_comb begin
        ball_y_next = ball_y_reg;
        vel_y_next  = vel_y_reg;
        state_next  = state_reg;
        case (state_reg)
            GROUND: begin
                ball_y_next = REST_Y;
                vel_y_next  = '0;
                // jump_armed blocks auto-repeat while the jump key is held
                if (keycode == KEY_JUMP && jump_armed_reg) begin
                    vel_y_next = NEG_JUMP_S;
                    state_next = RISING;
                end
            end
            RISING: begin
                if (ny < SIZE_S) begin
                    ball_y_next = SIZE_S[9:0];
                    vel_y_next  = '0;
                    state_next  = FALLING;
                end else begin
                    ball_y_next = ny[9:0];
                    vel_y_next  = vel_inc;
                    if (!vel_inc[10])
                        state_next = FALLING;
                end
            end
            FALLING: begin
                if (ny >= REST_S) begin
                    ball_y_next = REST_Y;
                    vel_y_next  = '0;
                    state_next  = GROUND;
                end else begin
                    ball_y_next = ny[9:0];
                    vel_y_next  = (vel_inc > MAXF_S) ? MAXF_S : vel_inc;
                end
            end
            default: begin
                ball_y_next = REST_Y;
                vel_y_next  = '0;
                state_next  = GROUND;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_reg      <= 1'b0;
            sync2_reg      <= 1'b0;
            prev_reg       <= 1'b0;
            ball_x_reg     <= 10'(X_START);
            ball_y_reg     <= REST_Y;
            vel_y_reg      <= '0;
            state_reg      <= GROUND;
            jump_armed_reg <= 1'b1;
            airborne_reg   <= 1'b0;
        end else begin
            sync1_reg <= frame_clk;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            if (tick) begin
                ball_x_reg     <= ball_x_next;
                ball_y_reg     <= ball_y_next;
                vel_y_reg      <= vel_y_next;
                state_reg      <= state_next;
                jump_armed_reg <= (keycode != KEY_JUMP);
                // decoded from the next state so it lines up with BallY
                airborne_reg   <= (state_next != GROUND);
            end
        end
    end

    assign BallX     = ball_x_reg;
    assign BallY     = ball_y_reg;
    assign Ball_size = 10'(SIZE);
    assign airborne  = airborne_reg;

endmodule

// File: tb/tb_player_ball_motion.sv
// Testbench for player_ball_motion: table-driven jump trajectory, directed
// corner sequences and randomized keys checked against a frame-level model.
module tb_player_ball_motion;

    localparam logic [7:0] K_NONE  = 8'h00;
    localparam logic [7:0] K_LEFT  = 8'h04;
    localparam logic [7:0] K_RIGHT = 8'h07;
    localparam logic [7:0] K_JUMP  = 8'h1A;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] BallX, BallY, Ball_size;
    logic       airborne;

    player_ball_motion dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .BallX     (BallX),
        .BallY     (BallY),
        .Ball_size (Ball_size),
        .airborne  (airborne)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level reference model, plain integer physics.
    int m_x, m_y, m_vy;
    bit m_air, m_up, m_armed;

    task automatic model_reset();
        m_x = 320; m_y = 396; m_vy = 0;
        m_air = 0; m_up = 0; m_armed = 1;
    endtask

    task automatic model_tick(input logic [7:0] key);
        int n;
        if (key == K_LEFT)  m_x = (m_x - 2 < 4)   ? 4   : m_x - 2;
        if (key == K_RIGHT) m_x = (m_x + 2 > 635) ? 635 : m_x + 2;
        if (!m_air) begin
            if (key == K_JUMP && m_armed) begin
                m_air = 1; m_up = 1; m_vy = -12;
            end
        end else if (m_up) begin
            n = m_y + m_vy;
            if (n < 4) begin
                m_y = 4; m_vy = 0; m_up = 0;
            end else begin
                m_y = n; m_vy = m_vy + 1;
                if (m_vy >= 0) m_up = 0;
            end
        end else begin
            n = m_y + m_vy;
            if (n >= 396) begin
                m_y = 396; m_vy = 0; m_air = 0;
            end else begin
                m_y = n; m_vy = (m_vy + 1 > 12) ? 12 : m_vy + 1;
            end
        end
        m_armed = (key != K_JUMP);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " BallX"}, int'(BallX), m_x);
        check({tag, " BallY"}, int'(BallY), m_y);
        check({tag, " airborne"}, int'(airborne), int'(m_air));
        check({tag, " Ball_size"}, int'(Ball_size), 4);
    endtask

    // One frame: frame_clk high 4 cycles, low 3 cycles, key held throughout.
    task automatic do_tick(input logic [7:0] key);
        @(negedge Clk);
        keycode   = key;
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic tick_and_check(input logic [7:0] key, input string tag);
        do_tick(key);
        model_tick(key);
        check_model(tag);
    endtask

    typedef struct {
        logic [7:0] key;
        int         ex;
        int         ey;
        bit         eair;
    } vec_t;

    vec_t vecs[26];
    int rise_y[12] = '{384, 373, 363, 354, 346, 339, 333, 328, 324, 321, 319, 318};
    int fall_y[12] = '{318, 319, 321, 324, 328, 333, 339, 346, 354, 363, 373, 384};

    initial begin
        // Jump trajectory table: jump tick, 12 rising, 12 falling, landing.
        vecs[0] = '{K_JUMP, 320, 396, 1'b1};
        for (int i = 0; i < 12; i++) begin
            vecs[1 + i]  = '{K_NONE, 320, rise_y[i], 1'b1};
            vecs[13 + i] = '{K_NONE, 320, fall_y[i], 1'b1};
        end
        vecs[25] = '{K_NONE, 320, 396, 1'b0};

        model_reset();
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check("reset BallX", int'(BallX), 320);
        check("reset BallY", int'(BallY), 396);
        check("reset airborne", int'(airborne), 0);
        check("reset Ball_size", int'(Ball_size), 4);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);

        // Keys without a frame tick must not move anything.
        keycode = K_LEFT;
        repeat (5) @(negedge Clk);
        keycode = K_JUMP;
        repeat (5) @(negedge Clk);
        keycode = K_NONE;
        repeat (2) @(negedge Clk);
        check_model("no-tick");

        // Full jump from the table.
        foreach (vecs[i]) begin
            do_tick(vecs[i].key);
            model_tick(vecs[i].key);
            check($sformatf("jump[%0d] BallX", i), int'(BallX), vecs[i].ex);
            check($sformatf("jump[%0d] BallY", i), int'(BallY), vecs[i].ey);
            check($sformatf("jump[%0d] airborne", i), int'(airborne), int'(vecs[i].eair));
        end

        // Held jump key: exactly one jump, none after landing.
        for (int i = 0; i < 31; i++) tick_and_check(K_JUMP, $sformatf("hold[%0d]", i));
        check("hold no rejump airborne", int'(airborne), 0);
        check("hold no rejump BallY", int'(BallY), 396);
        tick_and_check(K_NONE, "release");
        tick_and_check(K_JUMP, "rejump");
        check("rejump airborne", int'(airborne), 1);
        for (int i = 0; i < 26; i++) tick_and_check(K_NONE, $sformatf("land[%0d]", i));

        // Jump with RIGHT held, reset asserted mid-flight.
        tick_and_check(K_JUMP, "rj jump");
        for (int i = 1; i <= 5; i++) tick_and_check(K_RIGHT, $sformatf("rj[%0d]", i));
        @(negedge Clk);
        keycode = K_RIGHT;
        Reset   = 1'b0;
        #1;
        model_reset();
        check("midjump reset BallX", int'(BallX), 320);
        check("midjump reset BallY", int'(BallY), 396);
        check("midjump reset airborne", int'(airborne), 0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        // Left edge, then approach from BallX=5.
        for (int i = 0; i < 160; i++) do_tick(K_LEFT);
        for (int i = 0; i < 160; i++) model_tick(K_LEFT);
        check_model("left wall");
        for (int i = 0; i < 320; i++) do_tick(K_RIGHT);
        for (int i = 0; i < 320; i++) model_tick(K_RIGHT);
        check_model("right wall");
        for (int i = 0; i < 315; i++) do_tick(K_LEFT);
        for (int i = 0; i < 315; i++) model_tick(K_LEFT);
        check("at x=5", int'(BallX), 5);
        tick_and_check(K_LEFT, "x5 left");
        check("x5 left clamp", int'(BallX), 4);
        tick_and_check(K_LEFT, "x4 left hold");
        for (int i = 0; i < 315; i++) do_tick(K_RIGHT);
        for (int i = 0; i < 315; i++) model_tick(K_RIGHT);
        check("at x=634", int'(BallX), 634);
        tick_and_check(K_RIGHT, "x634 right");
        check("x634 right clamp", int'(BallX), 635);
        tick_and_check(K_RIGHT, "x635 right hold");

        // Long frame_clk high: exactly one update.
        for (int i = 0; i < 10; i++) tick_and_check(K_LEFT, $sformatf("pre-long[%0d]", i));
        @(negedge Clk);
        keycode   = K_LEFT;
        frame_clk = 1'b1;
        repeat (3000) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        model_tick(K_LEFT);
        check_model("long high");

        // Slow square-wave frames: one update per period.
        for (int p = 0; p < 3; p++) begin
            @(negedge Clk);
            keycode   = K_LEFT;
            frame_clk = 1'b1;
            repeat (100) @(negedge Clk);
            frame_clk = 1'b0;
            repeat (100) @(negedge Clk);
            model_tick(K_LEFT);
            check_model($sformatf("period[%0d]", p));
        end

        // Randomized keys against the model.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] k;
            case ($urandom_range(0, 5))
                0: k = K_NONE;
                1: k = K_LEFT;
                2: k = K_RIGHT;
                3: k = K_JUMP;
                4: k = K_JUMP;
                default: k = 8'($urandom);
            endcase
            tick_and_check(k, $sformatf("rand[%0d]", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
